// File: rtl/wave_generator_pkg.sv
// Shared definitions for the multi-mode wave generator: waveform select codes
// and default widths.
package wave_generator_pkg;

   typedef enum logic [1:0] {
      MODE_SQUARE = 2'd0,
      MODE_SAW    = 2'd1,
      MODE_TRI    = 2'd2,
      MODE_OFF    = 2'd3
   } wave_mode_e;

   localparam int RES_BITS_DEFAULT = 8;
   localparam int PHASE_W_DEFAULT  = 16;

endpackage

// File: rtl/wave_generator_phase_accumulator.sv
// Phase accumulator: adds freq each clock while enabled, holds phase at 0 when
// disabled. wrap is the carry out of the add, valid for the edge it precedes.
module phase_accumulator #(
   parameter int PHASE_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic [PHASE_W-1:0] freq,
   output logic [PHASE_W-1:0] phase,
   output logic               wrap
);

   logic [PHASE_W:0] sum;

   assign sum  = {1'b0, phase} + {1'b0, freq};
   assign wrap = enable & sum[PHASE_W];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase <= '0;
      end else if (enable) begin
         phase <= sum[PHASE_W-1:0];
      end else begin
         phase <= '0;
      end
   end

endmodule

// File: rtl/wave_generator.sv
// Multi-mode periodic waveform source: double-buffered config applied at period
// wrap, two-stage shape/scale pipeline, and a period_tick aligned to wave_out.
module wave_generator
   import wave_generator_pkg::*;
#(
   parameter int RES_BITS = RES_BITS_DEFAULT,
   parameter int PHASE_W  = PHASE_W_DEFAULT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic                cfg_load,
   input  logic [1:0]          cfg_mode,
   input  logic [PHASE_W-1:0]  cfg_freq,
   input  logic [RES_BITS-1:0] cfg_duty,
   input  logic [RES_BITS-1:0] cfg_amp,
   output logic                cfg_pending,
   output logic                period_tick,
   output logic [RES_BITS-1:0] wave_out
);

   wave_mode_e          shadow_mode, live_mode;
   logic [PHASE_W-1:0]  shadow_freq, live_freq;
   logic [RES_BITS-1:0] shadow_duty, live_duty;
   logic [RES_BITS-1:0] shadow_amp,  live_amp;

   logic [PHASE_W-1:0]  phase;
   logic                wrap;
   logic                apply;

   phase_accumulator #(.PHASE_W(PHASE_W)) u_phase (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .freq   (live_freq),
      .phase  (phase),
      .wrap   (wrap)
   );

   // Live config only changes at a period boundary, or freely while stopped.
   assign apply = cfg_pending & (wrap | ~enable);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow_mode <= MODE_SQUARE;
         shadow_freq <= '0;
         shadow_duty <= '0;
         shadow_amp  <= '0;
         live_mode   <= MODE_SQUARE;
         live_freq   <= '0;
         live_duty   <= '0;
         live_amp    <= '0;
         cfg_pending <= 1'b0;
      end else begin
         if (apply) begin
            live_mode <= shadow_mode;
            live_freq <= shadow_freq;
            live_duty <= shadow_duty;
            live_amp  <= shadow_amp;
         end
         if (cfg_load) begin
            shadow_mode <= wave_mode_e'(cfg_mode);
            shadow_freq <= cfg_freq;
            shadow_duty <= cfg_duty;
            shadow_amp  <= cfg_amp;
            cfg_pending <= 1'b1;
         end else if (apply) begin
            cfg_pending <= 1'b0;
         end
      end
   end

   logic [RES_BITS-1:0] top_bits;
   logic [RES_BITS-1:0] tri_bits;
   logic [RES_BITS-1:0] raw_next;

   assign top_bits = phase[PHASE_W-1 -: RES_BITS];
   assign tri_bits = phase[PHASE_W-2 -: RES_BITS];

   always_comb begin
      raw_next = '0;
      case (live_mode)
         MODE_SQUARE: raw_next = (top_bits < live_duty) ? '1 : '0;
         MODE_SAW:    raw_next = top_bits;
         MODE_TRI:    raw_next = phase[PHASE_W-1] ? ~tri_bits : tri_bits;
         default:     raw_next = '0;
      endcase
   end

   logic [RES_BITS-1:0]   raw;
   logic [RES_BITS-1:0]   amp_s1;
   logic                  tick_s0;
   logic                  tick_s1;
   logic [2*RES_BITS-1:0] product;

   // Amplitude travels with its sample so a wrap-time amp change cannot
   // rescale the last sample of the old period.
   assign product = ({{RES_BITS{1'b0}}, raw} * {{RES_BITS{1'b0}}, amp_s1})
                  + {{RES_BITS{1'b0}}, raw};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick_s0     <= 1'b0;
         tick_s1     <= 1'b0;
         raw         <= '0;
         amp_s1      <= '0;
         wave_out    <= '0;
         period_tick <= 1'b0;
      end else begin
         tick_s0     <= wrap;
         tick_s1     <= tick_s0;
         raw         <= raw_next;
         amp_s1      <= live_amp;
         wave_out    <= product[2*RES_BITS-1 -: RES_BITS];
         period_tick <= tick_s1;
      end
   end

endmodule

// File: tb/tb_wave_generator.sv
// Directed bench for wave_generator: square/saw/triangle periods, wrap-aligned
// config changes, coincident load, async reset and disabled hold.
module tb_wave_generator;
   import wave_generator_pkg::*;

   localparam int RB = 8;
   localparam int PW = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          enable = 1'b0;
   logic          cfg_load = 1'b0;
   logic [1:0]    cfg_mode = 2'd0;
   logic [PW-1:0] cfg_freq = '0;
   logic [RB-1:0] cfg_duty = '0;
   logic [RB-1:0] cfg_amp = '0;
   logic          cfg_pending;
   logic          period_tick;
   logic [RB-1:0] wave_out;

   int checks = 0;
   int failures = 0;
   logic [RB-1:0] exp_v [16];

   wave_generator #(.RES_BITS(RB), .PHASE_W(PW)) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .cfg_load    (cfg_load),
      .cfg_mode    (cfg_mode),
      .cfg_freq    (cfg_freq),
      .cfg_duty    (cfg_duty),
      .cfg_amp     (cfg_amp),
      .cfg_pending (cfg_pending),
      .period_tick (period_tick),
      .wave_out    (wave_out)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
      checks++;
      assert (obs === exp_val) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_val);
      end
   endtask

   task automatic load(input logic [1:0] mode, input logic [PW-1:0] freq,
                       input logic [RB-1:0] duty, input logic [RB-1:0] amp);
      cfg_mode = mode;
      cfg_freq = freq;
      cfg_duty = duty;
      cfg_amp  = amp;
      cfg_load = 1'b1;
      step();
      cfg_load = 1'b0;
   endtask

   task automatic wait_tick(input string tag);
      int n = 0;
      while (period_tick !== 1'b1 && n < 200) begin
         step();
         n++;
      end
      chk(tag, period_tick, 1);
   endtask

   task automatic count_to_tick(input string tag, input int exp_n);
      int n = 0;
      do begin
         step();
         n++;
      end while (period_tick !== 1'b1 && n < 64);
      chk(tag, n, exp_n);
   endtask

   // Starts on a tick sample; walks one period and expects the next tick.
   task automatic check_period(input string tag, input int len);
      for (int i = 0; i < len; i++) begin
         chk($sformatf("%s_wave[%0d]", tag, i), wave_out, exp_v[i]);
         chk($sformatf("%s_tick[%0d]", tag, i), period_tick, (i == 0) ? 1 : 0);
         step();
      end
      chk({tag, "_next_tick"}, period_tick, 1);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("reset_wave", wave_out, 0);
      chk("reset_tick", period_tick, 0);
      chk("reset_pending", cfg_pending, 0);
      reset = 1'b0;

      // Load while stopped: applied on the very next edge.
      load(MODE_SQUARE, 16'h1000, 8'h80, 8'hFF);
      chk("pending_after_load", cfg_pending, 1);
      step();
      chk("pending_applied_idle", cfg_pending, 0);
      enable = 1'b1;

      wait_tick("square_first_tick");
      exp_v = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      check_period("square", 16);

      // Mid-period switch to saw: square keeps running until the wrap.
      load(MODE_SAW, 16'h1000, 8'h00, 8'h7F);
      chk("saw_pending", cfg_pending, 1);
      chk("square_held", wave_out, 8'hFF);
      wait_tick("saw_tick");
      chk("saw_pending_clear", cfg_pending, 0);
      exp_v = '{8'h00, 8'h08, 8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
                8'h40, 8'h48, 8'h50, 8'h58, 8'h60, 8'h68, 8'h70, 8'h78};
      check_period("saw", 16);

      load(MODE_TRI, 16'h1000, 8'h00, 8'hFF);
      wait_tick("tri_tick");
      exp_v = '{8'h00, 8'h20, 8'h40, 8'h60, 8'h80, 8'hA0, 8'hC0, 8'hE0,
                8'hFF, 8'hDF, 8'hBF, 8'h9F, 8'h7F, 8'h5F, 8'h3F, 8'h1F};
      check_period("tri", 16);

      // Frequency doubles only after the current 16-clock period completes.
      load(MODE_TRI, 16'h2000, 8'h00, 8'hFF);
      chk("freq_pending", cfg_pending, 1);
      count_to_tick("old_period_len", 15);
      chk("freq_pending_clear", cfg_pending, 0);
      exp_v = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'hFF, 8'hBF, 8'h7F, 8'h3F,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      check_period("tri_fast", 8);

      // Config A pending, then config B loaded on the very edge A is applied.
      load(MODE_SAW, 16'h2000, 8'h00, 8'hFF);
      chk("a_pending", cfg_pending, 1);
      repeat (4) step();
      load(MODE_SAW, 16'h1000, 8'h00, 8'hFF);
      chk("b_pending_at_wrap", cfg_pending, 1);
      count_to_tick("coincident_to_tick", 2);
      chk("b_still_pending", cfg_pending, 1);
      exp_v = '{8'h00, 8'h20, 8'h40, 8'h60, 8'h80, 8'hA0, 8'hC0, 8'hE0,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      check_period("saw_a", 8);
      chk("b_applied", cfg_pending, 0);
      exp_v = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70,
                8'h80, 8'h90, 8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hE0, 8'hF0};
      check_period("saw_b", 16);

      // Asynchronous reset between clock edges with a load pending.
      load(MODE_SAW, 16'h1000, 8'h00, 8'h80);
      repeat (2) step();
      chk("pre_reset_wave", wave_out, 8'h30);
      chk("pre_reset_pending", cfg_pending, 1);
      reset = 1'b1;
      #2;
      chk("async_reset_wave", wave_out, 0);
      chk("async_reset_tick", period_tick, 0);
      chk("async_reset_pending", cfg_pending, 0);
      enable = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Disabled: phase held at 0 even with a nonzero frequency applied.
      load(MODE_SAW, 16'h1000, 8'h00, 8'hFF);
      step();
      chk("idle_pending_clear", cfg_pending, 0);
      for (int i = 0; i < 40; i++) begin
         chk($sformatf("idle_tick[%0d]", i), period_tick, 0);
         chk($sformatf("idle_wave[%0d]", i), wave_out, 0);
         step();
      end

      // Duty 0 square never goes high.
      load(MODE_SQUARE, 16'h1000, 8'h00, 8'hFF);
      step();
      enable = 1'b1;
      wait_tick("duty0_tick");
      exp_v = '{default: 8'h00};
      check_period("duty0", 16);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
